// File: rtl/reg_file.sv
// Register file with valid bits, two combinational read ports and a registered valid-entry count.
// Optional write-through bypass on the read ports is enabled by defining REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int data_width  = 8,
  parameter int switch_bits = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [switch_bits-1:0] wr_addr,
  input  logic [data_width-1:0]  wr_data,
  input  logic                   clr_en,
  input  logic [switch_bits-1:0] clr_addr,
  input  logic [switch_bits-1:0] rd_addr_a,
  input  logic [switch_bits-1:0] rd_addr_b,
  output logic [data_width-1:0]  rd_data_a,
  output logic [data_width-1:0]  rd_data_b,
  output logic                   rd_valid_a,
  output logic                   rd_valid_b,
  output logic [switch_bits:0]   valid_count
);

  localparam int depth = 1 << switch_bits;

  logic [data_width-1:0] entry_reg [depth];
  logic [depth-1:0]      valid_reg;
  logic [switch_bits:0]  count_reg;
  logic [switch_bits:0]  count_next;
  logic                  count_inc;
  logic                  count_dec;

  // Clear is applied first so a write to the same entry overrides it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < depth; i++) begin
        entry_reg[i] <= '0;
      end
      valid_reg <= '0;
      count_reg <= '0;
    end else begin
      if (clr_en) begin
        valid_reg[clr_addr] <= 1'b0;
      end
      if (wr_en) begin
        entry_reg[wr_addr] <= wr_data;
        valid_reg[wr_addr] <= 1'b1;
      end
      count_reg <= count_next;
    end
  end

  always_comb begin
    count_inc  = wr_en && !valid_reg[wr_addr];
    count_dec  = clr_en && valid_reg[clr_addr] && !(wr_en && (wr_addr == clr_addr));
    count_next = count_reg;
    if (count_inc && !count_dec) begin
      count_next = count_reg + 1'b1;
    end else if (count_dec && !count_inc) begin
      count_next = count_reg - 1'b1;
    end
  end

  assign valid_count = count_reg;

`ifdef REG_FILE_BYPASS_EN
  logic hit_a;
  logic hit_b;

  assign hit_a      = rst && wr_en && (rd_addr_a == wr_addr);
  assign hit_b      = rst && wr_en && (rd_addr_b == wr_addr);
  assign rd_data_a  = hit_a ? wr_data : entry_reg[rd_addr_a];
  assign rd_data_b  = hit_b ? wr_data : entry_reg[rd_addr_b];
  assign rd_valid_a = hit_a | valid_reg[rd_addr_a];
  assign rd_valid_b = hit_b | valid_reg[rd_addr_b];
`else
  assign rd_data_a  = entry_reg[rd_addr_a];
  assign rd_data_b  = entry_reg[rd_addr_b];
  assign rd_valid_a = valid_reg[rd_addr_a];
  assign rd_valid_b = valid_reg[rd_addr_b];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: directed scenarios plus random traffic against an array model.
// Expected read behaviour follows REG_FILE_BYPASS_EN when it is defined for the build.
module tb_reg_file;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       clr_en;
  logic [2:0] clr_addr;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic       rd_valid_a;
  logic       rd_valid_b;
  logic [3:0] valid_count;

  reg_file #(.data_width(8), .switch_bits(3)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_en(clr_en), .clr_addr(clr_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
    .valid_count(valid_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] da;
    logic       va;
    logic [7:0] db;
    logic       vb;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   txn    = 0;

  logic [7:0] mem [8];
  bit         vld [8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] model_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += vld[i] ? 1 : 0;
    return 4'(n);
  endfunction

  function automatic bit bypass_hit(input bit r, input bit w, input logic [2:0] wa, input logic [2:0] ra);
`ifdef REG_FILE_BYPASS_EN
    return r && w && (wa == ra);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle, predict the outputs seen before the edge, then commit the edge to the model.
  task automatic cycle(input bit r, input bit w, input logic [2:0] wa, input logic [7:0] wd,
                       input bit c, input logic [2:0] ca, input logic [2:0] ra, input logic [2:0] rb);
    exp_t e;
    rst = r; wr_en = w; wr_addr = wa; wr_data = wd;
    clr_en = c; clr_addr = ca; rd_addr_a = ra; rd_addr_b = rb;
    e.da  = bypass_hit(r, w, wa, ra) ? wd : mem[ra];
    e.va  = bypass_hit(r, w, wa, ra) ? 1'b1 : vld[ra];
    e.db  = bypass_hit(r, w, wa, rb) ? wd : mem[rb];
    e.vb  = bypass_hit(r, w, wa, rb) ? 1'b1 : vld[rb];
    e.cnt = model_count();
    sb.push_back(e);
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 8; i++) begin mem[i] = 8'h00; vld[i] = 1'b0; end
    end else begin
      if (c) vld[ca] = 1'b0;
      if (w) begin mem[wa] = wd; vld[wa] = 1'b1; end
    end
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      txn++;
      $display("txn %0d: a=%h/%b b=%h/%b count=%0d", txn, rd_data_a, rd_valid_a,
               rd_data_b, rd_valid_b, valid_count);
      check("rd_data_a", rd_data_a, e.da);
      check("rd_valid_a", {7'd0, rd_valid_a}, {7'd0, e.va});
      check("rd_data_b", rd_data_b, e.db);
      check("rd_valid_b", {7'd0, rd_valid_b}, {7'd0, e.vb});
      check("valid_count", {4'd0, valid_count}, {4'd0, e.cnt});
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin mem[i] = 8'h00; vld[i] = 1'b0; end
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    clr_en = 1'b0; clr_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    @(posedge clk);
    #1;

    // Reset state on every address
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'h00, 0, 0, 3'(i), 3'(7 - i));

    // Single write, both ports on the same entry
    cycle(1, 1, 3, 8'hA5, 0, 0, 0, 0);
    cycle(1, 0, 0, 8'h00, 0, 0, 3, 3);

    // Write and clear on the same entry, then clear alone
    cycle(1, 1, 5, 8'h3C, 1, 5, 5, 3);
    cycle(1, 0, 0, 8'h00, 1, 5, 5, 5);
    cycle(1, 0, 0, 8'h00, 0, 0, 5, 3);
    check("clear_keeps_data", rd_data_a, 8'h3C);

    // Fill, saturate, rewrite and same-cycle clear+write at full depth
    for (int i = 0; i < 8; i++) cycle(1, 1, 3'(i), 8'(8'h10 + i), 0, 0, 3'(i), 0);
    cycle(1, 1, 0, 8'hFF, 0, 0, 0, 7);
    check("count_full", {4'd0, valid_count}, 8'd8);
    cycle(1, 1, 7, 8'hEE, 1, 7, 7, 0);
    cycle(1, 0, 0, 8'h00, 0, 0, 7, 0);
    check("count_full_after_clr_wr", {4'd0, valid_count}, 8'd8);

    // Write-through vs. pre-write read after a fresh reset
    cycle(0, 0, 0, 8'h00, 0, 0, 0, 0);
    cycle(1, 1, 2, 8'h11, 0, 0, 2, 2);
    cycle(1, 0, 0, 8'h00, 0, 0, 2, 1);

    // Write during reset is discarded
    cycle(0, 1, 1, 8'h77, 0, 0, 1, 1);
    cycle(1, 0, 0, 8'h00, 0, 0, 1, 2);
    check("reset_discards_write", {4'd0, valid_count}, 8'd0);

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      cycle(($urandom_range(0, 31) != 0), $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            8'($urandom), $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: data_width, default 8, bits per entry (legal 1..64).
REQ-002 Parameter: switch_bits, default 3, address bits; depth = 2^switch_bits entries (legal 1..6).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; ports are clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 wr_en  input  1  write strobe.
REQ-007 wr_addr  input  switch_bits  write entry index.
REQ-008 wr_data  input  data_width  write data.
REQ-009 clr_en  input  1  invalidate strobe.
REQ-010 clr_addr  input  switch_bits  entry to invalidate.
REQ-011 rd_addr_a / rd_addr_b  input  switch_bits each  read port A/B index.
REQ-012 rd_data_a / rd_data_b  output  data_width each  read port A/B data.
REQ-013 rd_valid_a / rd_valid_b  output  1 each  valid bit of the addressed entry.
REQ-014 valid_count  output  switch_bits+1  number of valid entries, 0..depth.

Function
REQ-015 Storage SHALL be depth entries of data_width bits, each with one valid bit.
REQ-016 With wr_en=1 at a rising edge, entry[wr_addr] SHALL take wr_data and its valid bit SHALL set; write latency 1 cycle.
REQ-017 With clr_en=1 at a rising edge, valid[clr_addr] SHALL clear; entry data SHALL be unchanged.
REQ-018 With wr_en=1 and clr_en=1 on the same address, the write SHALL win (valid=1, new data).
REQ-019 With wr_en=1 and clr_en=1 on different addresses, both SHALL take effect in the same cycle.
REQ-020 Read ports SHALL be combinational: rd_data_x = entry[rd_addr_x], rd_valid_x = valid[rd_addr_x], selected by a 2^switch_bits-way mux tree.
REQ-021 Both read ports SHALL be independent and may address the same entry.
REQ-022 valid_count SHALL be registered and track the valid bits after every edge: +1 on write to an invalid entry, -1 on clear of a valid entry, net 0 on same-cycle write-new plus clear-valid, unchanged on rewrite of a valid entry or clear of an invalid entry.
REQ-023 valid_count SHALL never exceed depth nor go below 0; at depth it stays depth on rewrites.
REQ-024 Out-of-range addresses are impossible by construction (full decode); no error output.

Reset
REQ-025 With rst=0 at a rising edge, all entry data SHALL become 0, all valid bits 0, valid_count 0.
REQ-026 Reset SHALL take priority over wr_en and clr_en in the same cycle; a write during reset is discarded.
REQ-027 After reset release, rd_data_x=0 and rd_valid_x=0 for every address until written.

Configuration
REQ-028 Macro REG_FILE_BYPASS_EN SHALL select write-through bypass.
REQ-029 With REG_FILE_BYPASS_EN defined: when wr_en=1 and rd_addr_x=wr_addr in the same cycle (rst=1), rd_data_x SHALL equal wr_data and rd_valid_x SHALL be 1 combinationally.
REQ-030 With REG_FILE_BYPASS_EN undefined: reads in that cycle SHALL return the pre-write entry and valid bit; new value visible next cycle.
REQ-031 Bypass SHALL be suppressed while rst=0.

Verification (data_width=8, switch_bits=3)
REQ-032 Reset: rst=0 one cycle, then read all 8 addresses -> rd_data=0x00, rd_valid=0, valid_count=0.
REQ-033 Write 0xA5 to addr 3, next cycle rd_addr_a=3, rd_addr_b=3 -> both ports 0xA5, valid=1, valid_count=1.
REQ-034 Same-cycle write 0x3C to addr 5 and clr addr 5 -> entry 5 = 0x3C, valid=1; then clr addr 5 alone -> valid=0, data still 0x3C, count decremented.
REQ-035 Write all 8 addresses, then rewrite addr 0 with 0xFF -> valid_count=8 and stays 8; clr addr 7 + write addr 7 same cycle -> count 8.
REQ-036 Write 0x11 to addr 2 with rd_addr_a=2 same cycle -> 0x11 with REG_FILE_BYPASS_EN, prior value (0x00, valid 0 after reset) without.
REQ-037 Write 0x77 to addr 1 with rst=0 same cycle -> entry 1 = 0x00, valid 0, valid_count 0.
